// File: rtl/line_memory_pkg.sv
// Shared constants and FSM state type for the line-granular main-memory model.
package line_memory_pkg;

    localparam int LINE_OFFSET_BITS  = 5;
    localparam int DEFAULT_LINE_BITS = 256;
    localparam int DEFAULT_ADDR_BITS = 32;
    localparam int COUNT_BITS        = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

endpackage

// File: rtl/line_ram.sv
// Single-port line storage: synchronous write, registered read that holds until the next read.
module line_ram
    import line_memory_pkg::*;
#(
    parameter int LINE_BITS  = DEFAULT_LINE_BITS,
    parameter int INDEX_BITS = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [INDEX_BITS-1:0] index_i,
    input  logic [LINE_BITS-1:0]  wdata_i,
    output logic [LINE_BITS-1:0]  rdata_o
);

    logic [LINE_BITS-1:0] mem [2**INDEX_BITS];
    logic [LINE_BITS-1:0] rdata_reg;

    // The array itself is never reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[index_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_reg <= '0;
        end else if (re_i) begin
            rdata_reg <= mem[index_i];
        end
    end

    assign rdata_o = rdata_reg;

endmodule

// File: rtl/line_memory.sv
// Fixed-latency main-memory model serving one cache-line read or write per request.
module line_memory
    import line_memory_pkg::*;
#(
    parameter int LINE_BITS  = DEFAULT_LINE_BITS,
    parameter int ADDR_BITS  = DEFAULT_ADDR_BITS,
    parameter int INDEX_BITS = 9,
    parameter int LATENCY    = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [LINE_BITS-1:0] data_i,
    input  logic                 enable_i,
    input  logic                 write_i,
    output logic                 ack_o,
    output logic [LINE_BITS-1:0] data_o
);

    localparam logic [COUNT_BITS-1:0] COUNT_LOAD = COUNT_BITS'(LATENCY - 2);

    state_t                  state_reg;
    logic [COUNT_BITS-1:0]   count_reg;
    logic [INDEX_BITS-1:0]   index_reg;
    logic [LINE_BITS-1:0]    wdata_reg;
    logic                    write_reg;
    logic                    access;
    logic                    unused_addr_bits;

    // Offset bits and bits above the index do not select a line.
    assign unused_addr_bits = ^{addr_i[ADDR_BITS-1:LINE_OFFSET_BITS+INDEX_BITS],
                                addr_i[LINE_OFFSET_BITS-1:0]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enable_i) begin
                        state_reg <= WAIT;
                        count_reg <= COUNT_LOAD;
                    end
                end
                WAIT: begin
                    if (count_reg == '0) begin
                        state_reg <= ACK;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                ACK: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Request fields are captured only when IDLE accepts a request.
    always_ff @(posedge clk_i) begin
        if (state_reg == IDLE && enable_i) begin
            index_reg <= addr_i[LINE_OFFSET_BITS +: INDEX_BITS];
            wdata_reg <= data_i;
            write_reg <= write_i;
        end
    end

    // The access lands on the WAIT->ACK edge, so a reset during WAIT commits nothing.
    assign access = (state_reg == WAIT) && (count_reg == '0);

    line_ram #(
        .LINE_BITS  (LINE_BITS),
        .INDEX_BITS (INDEX_BITS)
    ) u_line_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (access && write_reg),
        .re_i    (access && !write_reg),
        .index_i (index_reg),
        .wdata_i (wdata_reg),
        .rdata_o (data_o)
    );

    assign ack_o = (state_reg == ACK);

endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory: timeline-based reference model plus literal latency/data checks.
module tb_line_memory;

    localparam int LAT = 10;

    logic         clk_i    = 1'b0;
    logic         rst_i    = 1'b1;
    logic [31:0]  addr_i   = '0;
    logic [255:0] data_i   = '0;
    logic         enable_i = 1'b0;
    logic         write_i  = 1'b0;
    logic         ack_o;
    logic [255:0] data_o;

    int checks   = 0;
    int failures = 0;

    line_memory #(
        .LINE_BITS  (256),
        .ADDR_BITS  (32),
        .INDEX_BITS (9),
        .LATENCY    (LAT)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .ack_o    (ack_o),
        .data_o   (data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a request sampled in cycle t0 completes in cycle t0+LAT,
    // and the next request can only be taken from cycle t0+LAT+1.
    int           cyc = 0;
    logic         m_pend = 1'b0;
    int           m_ack_at = 0;
    logic         m_wr = 1'b0;
    logic [8:0]   m_idx = '0;
    logic [255:0] m_data = '0;
    logic         exp_ack = 1'b0;
    logic [255:0] exp_data = '0;
    logic [255:0] model_mem [512];

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_pend   <= 1'b0;
            exp_ack  <= 1'b0;
            exp_data <= '0;
        end else begin
            cyc <= cyc + 1;
            if (m_pend) begin
                if (cyc == m_ack_at) begin
                    m_pend  <= 1'b0;
                    exp_ack <= 1'b0;
                end else if (cyc + 1 == m_ack_at) begin
                    exp_ack <= 1'b1;
                    if (m_wr) model_mem[m_idx] <= m_data;
                    else      exp_data <= model_mem[m_idx];
                end
            end else if (enable_i) begin
                m_pend   <= 1'b1;
                m_ack_at <= cyc + LAT;
                m_wr     <= write_i;
                m_idx    <= addr_i[13:5];
                m_data   <= data_i;
            end
        end
    end

    logic         cmp_on = 1'b0;
    int           ack_count = 0;
    int           last_ack_cyc = 0;
    logic [255:0] last_ack_data = '0;

    always @(negedge clk_i) begin
        if (cmp_on) begin
            check("cycle_ack", {255'd0, ack_o}, {255'd0, exp_ack});
            check("cycle_data", data_o, exp_data);
            if (ack_o) begin
                ack_count     = ack_count + 1;
                last_ack_cyc  = cyc;
                last_ack_data = data_o;
            end
        end
    end

    task automatic next_cycle();
        @(negedge clk_i);
        #1;
    endtask

    task automatic wait_ack(input bit check_low);
        int start;
        start = ack_count;
        for (int i = 0; i < 3 * LAT && ack_count == start; i++) next_cycle();
        if (ack_count == start) begin
            check("ack_timeout", 256'd0, 256'd1);
        end else if (check_low) begin
            next_cycle();
            check("ack_single_pulse", {255'd0, ack_o}, 256'd0);
        end
        $display("txn: ack at cycle %0d data_o=%h", last_ack_cyc, last_ack_data);
    endtask

    task automatic do_req(input logic wr, input logic [31:0] a, input logic [255:0] d, output int t0);
        @(posedge clk_i);
        #1;
        enable_i = 1'b1;
        write_i  = wr;
        addr_i   = a;
        data_i   = d;
        t0       = cyc;
        @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        wait_ack(1'b1);
    endtask

    logic [255:0] pat_a5;
    logic [255:0] pat_12;
    logic [255:0] old7;
    logic [255:0] new7;
    int           t0;
    int           start_acks;
    int           acks [3];

    initial begin
        pat_a5 = {32{8'hA5}};
        pat_12 = {16{16'h1234}};
        old7   = {8{32'hDEAD_0007}};
        new7   = {8{32'h0BAD_F00D}};

        // Reset asserted mid-cycle must clear outputs at once.
        #12 rst_i = 1'b0;
        #1;
        check("reset_ack", {255'd0, ack_o}, 256'd0);
        check("reset_data", data_o, 256'd0);
        repeat (2) @(negedge clk_i);
        rst_i  = 1'b1;
        cmp_on = 1'b1;

        do_req(1'b1, 32'h0000_0060, pat_a5, t0);
        do_req(1'b1, 32'h0000_00E0, old7, t0);

        // Read latency: ack exactly LAT cycles after sampling.
        do_req(1'b0, 32'h0000_0060, '0, t0);
        check("rd_latency", 256'(last_ack_cyc), 256'(t0 + 10));
        check("rd_data", last_ack_data, pat_a5);

        @(posedge clk_i);
        #3 rst_i = 1'b0;
        #1;
        check("midcycle_reset_ack", {255'd0, ack_o}, 256'd0);
        check("midcycle_reset_data", data_o, 256'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        do_req(1'b1, 32'h0000_0400, pat_12, t0);
        check("wr_latency", 256'(last_ack_cyc), 256'(t0 + 10));
        check("wr_keeps_data_o", last_ack_data, 256'd0);
        do_req(1'b0, 32'h0000_0400, '0, t0);
        check("wr_rd_data", last_ack_data, pat_12);
        do_req(1'b0, 32'h0000_4400, '0, t0);
        check("alias_data", last_ack_data, pat_12);
        do_req(1'b0, 32'h0000_041F, '0, t0);
        check("offset_data", last_ack_data, pat_12);

        // Busy inputs: everything toggles during WAIT, only the t0 request completes.
        start_acks = ack_count;
        @(posedge clk_i);
        #1;
        enable_i = 1'b1; write_i = 1'b0; addr_i = 32'h0000_0060; data_i = '0;
        t0 = cyc;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk_i);
            #1;
            enable_i = i[0];
            write_i  = ~write_i;
            addr_i   = 32'h0000_0060 ^ (32'(i) << 5);
            data_i   = {8{$urandom()}};
        end
        @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        wait_ack(1'b1);
        repeat (LAT + 3) next_cycle();
        check("busy_ack_count", 256'(ack_count - start_acks), 256'd1);
        check("busy_latency", 256'(last_ack_cyc), 256'(t0 + 10));
        check("busy_data", last_ack_data, pat_a5);
        do_req(1'b0, 32'h0000_0400, '0, t0);
        check("busy_no_stray_write", last_ack_data, pat_12);

        // Back-to-back: enable held high, acks every LAT+1 cycles.
        @(posedge clk_i);
        #1;
        enable_i = 1'b1; write_i = 1'b0; addr_i = 32'h0000_0060;
        t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            wait_ack(1'b0);
            acks[k] = last_ack_cyc;
        end
        enable_i = 1'b0;
        next_cycle();
        check("b2b_ack_low", {255'd0, ack_o}, 256'd0);
        check("b2b_ack0", 256'(acks[0]), 256'(t0 + 10));
        check("b2b_ack1", 256'(acks[1]), 256'(t0 + 21));
        check("b2b_ack2", 256'(acks[2]), 256'(t0 + 32));

        // Reset during a write to line 7 discards it.
        @(posedge clk_i);
        #1;
        enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h0000_00E0; data_i = new7;
        t0 = cyc;
        @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        while (cyc < t0 + 5) begin
            @(posedge clk_i);
            #1;
        end
        #2 rst_i = 1'b0;
        #1;
        check("rst_write_ack", {255'd0, ack_o}, 256'd0);
        check("rst_write_data", data_o, 256'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        start_acks = ack_count;
        repeat (LAT + 5) next_cycle();
        check("rst_write_no_ack", 256'(ack_count - start_acks), 256'd0);
        do_req(1'b0, 32'h0000_00E0, '0, t0);
        check("rst_write_old_value", last_ack_data, old7);

        repeat (2) next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
